// File: rtl/xs3_pkg.sv
// Shared excess-3 constants and the decoder state type.
package xs3_pkg;

    localparam logic [3:0] XS3_OFFSET = 4'd3;
    localparam logic [3:0] XS3_MIN    = 4'h3;
    localparam logic [3:0] XS3_MAX    = 4'hC;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } xs3_dec_state_t;

endpackage

// File: rtl/xs3_digit_decode.sv
// Combinational excess-3 digit decoder: value plus illegal-code flag.
module xs3_digit_decode
    import xs3_pkg::*;
(
    input  logic [3:0] code,
    output logic [3:0] digit,
    output logic       illegal
);

    assign illegal = (code < XS3_MIN) || (code > XS3_MAX);
    // Illegal codes contribute nothing to the accumulator.
    assign digit   = illegal ? 4'd0 : (code - XS3_OFFSET);

endmodule

// File: rtl/xs3_to_binary_decoder.sv
// Streaming XS-3 digit frame to binary decoder with valid/ready on both sides.
// Optional XS3_DEC_ERR_CNT_EN adds a saturating count of errored results.
module xs3_to_binary_decoder
    import xs3_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int OUT_W      = 14
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [3:0]                        in_digit,
    input  logic                              in_last,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [OUT_W-1:0]                  out_value,
    output logic [$clog2(NUM_DIGITS+1)-1:0]   out_ndigits,
`ifdef XS3_DEC_ERR_CNT_EN
    output logic [7:0]                        err_count,
`endif
    output logic                              out_error
);

    localparam int CNT_W = $clog2(NUM_DIGITS + 1);

    xs3_dec_state_t    state_reg;
    logic [OUT_W-1:0]  acc_reg;
    logic [CNT_W-1:0]  cnt_reg;
    logic              err_ill_reg;
    logic              err_ovf_reg;
    logic [OUT_W-1:0]  out_value_reg;
    logic [CNT_W-1:0]  out_ndigits_reg;
    logic              out_error_reg;

    logic [3:0]        dig;
    logic              dig_illegal;
    logic              accept;
    logic              frame_start;
    logic              at_limit;
    logic [OUT_W-1:0]  base_acc;
    logic [CNT_W-1:0]  base_cnt;
    logic              base_ill;
    logic              base_ovf;
    logic [OUT_W-1:0]  acc_next;
    logic [CNT_W-1:0]  cnt_next;
    logic              err_ill_next;
    logic              err_ovf_next;

    xs3_digit_decode u_dec (
        .code    (in_digit),
        .digit   (dig),
        .illegal (dig_illegal)
    );

    assign in_ready  = (state_reg != HOLD);
    assign out_valid = (state_reg == HOLD);
    assign accept    = in_valid && in_ready;

    always_comb begin
        frame_start  = (state_reg == IDLE);
        // A digit accepted in IDLE starts from a clean frame context.
        base_acc     = frame_start ? '0   : acc_reg;
        base_cnt     = frame_start ? '0   : cnt_reg;
        base_ill     = frame_start ? 1'b0 : err_ill_reg;
        base_ovf     = frame_start ? 1'b0 : err_ovf_reg;
        at_limit     = (base_cnt == CNT_W'(NUM_DIGITS));
        acc_next     = at_limit ? base_acc
                                : ((base_acc << 3) + (base_acc << 1) + OUT_W'(dig));
        cnt_next     = at_limit ? base_cnt : (base_cnt + 1'b1);
        err_ill_next = base_ill | dig_illegal;
        err_ovf_next = base_ovf | at_limit;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= IDLE;
            acc_reg         <= '0;
            cnt_reg         <= '0;
            err_ill_reg     <= 1'b0;
            err_ovf_reg     <= 1'b0;
            out_value_reg   <= '0;
            out_ndigits_reg <= '0;
            out_error_reg   <= 1'b0;
        end else if (accept) begin
            acc_reg     <= acc_next;
            cnt_reg     <= cnt_next;
            err_ill_reg <= err_ill_next;
            err_ovf_reg <= err_ovf_next;
            if (in_last) begin
                out_value_reg   <= (err_ill_next | err_ovf_next) ? '0 : acc_next;
                out_ndigits_reg <= cnt_next;
                out_error_reg   <= err_ill_next | err_ovf_next;
                state_reg       <= HOLD;
            end else begin
                state_reg <= ACCUM;
            end
        end else if (out_valid && out_ready) begin
            state_reg <= IDLE;
        end
    end

    assign out_value   = out_value_reg;
    assign out_ndigits = out_ndigits_reg;
    assign out_error   = out_error_reg;

`ifdef XS3_DEC_ERR_CNT_EN
    logic [7:0] err_count_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            err_count_reg <= 8'd0;
        end else if (out_valid && out_ready && out_error_reg && (err_count_reg != 8'hFF)) begin
            err_count_reg <= err_count_reg + 8'd1;
        end
    end

    assign err_count = err_count_reg;
`endif

endmodule

// File: tb/tb_xs3_to_binary_decoder.sv
// Directed-vector bench for xs3_to_binary_decoder (NUM_DIGITS=4, OUT_W=14).
module tb_xs3_to_binary_decoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_digit;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [13:0] out_value;
    logic [2:0]  out_ndigits;
    logic        out_error;
`ifdef XS3_DEC_ERR_CNT_EN
    logic [7:0]  err_count;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    xs3_to_binary_decoder #(.NUM_DIGITS(4), .OUT_W(14)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_digit    (in_digit),
        .in_last     (in_last),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_value   (out_value),
        .out_ndigits (out_ndigits),
`ifdef XS3_DEC_ERR_CNT_EN
        .err_count   (err_count),
`endif
        .out_error   (out_error)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end else begin
            $display("ok   %s: %0d", tag, obs);
        end
    endtask

    // Present one digit for exactly one clock edge; inputs change 1 time unit after the edge.
    task automatic put(input logic [3:0] code, input logic last);
        in_valid = 1'b1;
        in_digit = code;
        in_last  = last;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Result must be presented now; complete the handshake and confirm release.
    task automatic take(input string tag, input int val, input int nd, input int err);
        check({tag, ".valid"},   32'(out_valid),   1);
        check({tag, ".value"},   32'(out_value),   32'(val));
        check({tag, ".ndigits"}, 32'(out_ndigits), 32'(nd));
        check({tag, ".error"},   32'(out_error),   32'(err));
        check({tag, ".in_rdy0"}, 32'(in_ready),    0);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({tag, ".released"}, 32'(out_valid), 0);
        check({tag, ".in_rdy1"},  32'(in_ready),  1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        in_valid  = 1'b0;
        in_digit  = 4'h0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        do_reset();

        check("rst.in_ready",  32'(in_ready),    1);
        check("rst.out_valid", 32'(out_valid),   0);
        check("rst.value",     32'(out_value),   0);
        check("rst.ndigits",   32'(out_ndigits), 0);
        check("rst.error",     32'(out_error),   0);

        // 1234 with out_ready held high: valid one cycle after the last accept
        out_ready = 1'b1;
        put(4'h4, 1'b0);
        put(4'h5, 1'b0);
        put(4'h6, 1'b0);
        put(4'h7, 1'b1);
        check("f1234.valid",   32'(out_valid),   1);
        check("f1234.value",   32'(out_value),   1234);
        check("f1234.ndigits", 32'(out_ndigits), 4);
        check("f1234.error",   32'(out_error),   0);
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("f1234.released", 32'(out_valid), 0);
        check("f1234.in_rdy",   32'(in_ready),  1);

        // Legal code boundaries
        put(4'hC, 1'b1);
        take("d9", 9, 1, 0);
        put(4'h3, 1'b1);
        take("d0", 0, 1, 0);
        put(4'hC, 1'b0);
        put(4'hC, 1'b0);
        put(4'hC, 1'b1);
        take("d999", 999, 3, 0);

        // Illegal codes, including both edges of the illegal range
        put(4'h4, 1'b0);
        put(4'hE, 1'b0);
        put(4'h5, 1'b1);
        take("ill_mid", 0, 3, 1);
        put(4'hD, 1'b1);
        take("ill_D", 0, 1, 1);
        put(4'h2, 1'b1);
        take("ill_2", 0, 1, 1);

        // Five digits into a four-digit frame
        for (int i = 0; i < 4; i++) put(4'h4, 1'b0);
        put(4'h4, 1'b1);
        take("ovf", 0, 4, 1);

        // Error flags are per-frame: a clean frame follows
        put(4'h5, 1'b0);
        put(4'h3, 1'b1);
        take("after_err", 20, 2, 0);

        // Back-pressure: result stable and inputs ignored while held
        put(4'h7, 1'b1);
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_digit = 4'h9;
            in_last  = 1'b1;
            check("hold.valid",    32'(out_valid), 1);
            check("hold.value",    32'(out_value), 4);
            check("hold.in_ready", 32'(in_ready),  0);
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        check("hold.value4", 32'(out_value), 4);
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("hold.released", 32'(out_valid), 0);
        check("hold.in_rdy",   32'(in_ready),  1);
        put(4'h8, 1'b1);
        take("after_hold", 5, 1, 0);

        // Reset mid-frame discards the partial frame
        put(4'h5, 1'b0);
        put(4'h6, 1'b0);
        do_reset();
        check("rst_mid.valid", 32'(out_valid), 0);
        check("rst_mid.in_rdy", 32'(in_ready), 1);
        put(4'h8, 1'b1);
        take("rst_mid", 5, 1, 0);

        // Reset in HOLD discards the pending result
        put(4'h4, 1'b1);
        check("rst_hold.pre", 32'(out_valid), 1);
        do_reset();
        check("rst_hold.valid", 32'(out_valid), 0);
        check("rst_hold.value", 32'(out_value), 0);
        put(4'h6, 1'b0);
        put(4'h3, 1'b1);
        take("rst_hold", 30, 2, 0);

`ifdef XS3_DEC_ERR_CNT_EN
        do_reset();
        check("errcnt.rst", 32'(err_count), 0);
        put(4'hF, 1'b1);
        take("errcnt.f1", 0, 1, 1);
        put(4'h4, 1'b0);
        put(4'h0, 1'b1);
        take("errcnt.f2", 0, 2, 1);
        put(4'h4, 1'b1);
        take("errcnt.ok", 1, 1, 0);
        check("errcnt.two", 32'(err_count), 2);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
